// File: rtl/pe_is_multictx.sv
// Input-stationary multi-context MAC processing element: a two-stage pipe with zero gating,
// a local accumulator bank addressed by ctx_sel, and serial scan readout of that bank.
module pe_is_multictx #(
    parameter int WIDTH_A     = 16,
    parameter int WIDTH_B     = 16,
    parameter int WIDTH_MAC   = 48,
    parameter int LANES       = 2,
    parameter int NUM_CTX     = 2,
    parameter int WIDTH_T     = 4,
    parameter int ZERO_GATING = 1,
    localparam int CW         = $clog2(NUM_CTX),
    localparam int WIDTH_P    = WIDTH_A + WIDTH_B
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [LANES*WIDTH_A-1:0]   a_in,
    input  logic [LANES*WIDTH_B-1:0]   b_in,
    input  logic [WIDTH_MAC-1:0]       mac_in,
    input  logic                       valid_in,
    input  logic                       pipeline_en,
    input  logic                       cell_en,
    input  logic                       cell_sc_en,
    input  logic                       reg_clear,
    input  logic                       ctx_switch,
    input  logic [CW-1:0]              ctx_sel,
    input  logic [WIDTH_T-1:0]         thres,
    input  logic                       scan_en,
    input  logic                       scan_in,
    output logic [WIDTH_MAC-1:0]       mac_out,
    output logic                       valid_out,
    output logic                       cell_out,
    output logic                       scan_out,
    output logic [LANES-1:0]           zero_lanes
);

    logic                              adv;
    logic [LANES-1:0]                  gate;
    logic signed [WIDTH_A-1:0]         op_a [LANES];
    logic signed [WIDTH_B-1:0]         op_b [LANES];
    logic signed [WIDTH_P-1:0]         prod_next [LANES];
    logic signed [WIDTH_P-1:0]         prod [LANES];
    logic                              s1_valid;
    logic                              s1_ctx_switch;
    logic [CW-1:0]                     s1_ctx_sel;
    logic [NUM_CTX-1:0][WIDTH_MAC-1:0] acc;
    logic [NUM_CTX*WIDTH_MAC-1:0]      acc_flat;
    logic [WIDTH_MAC-1:0]              addend;
    logic [WIDTH_MAC-1:0]              sum;

    assign adv      = pipeline_en & cell_en & ~scan_en;
    assign acc_flat = acc;
    assign scan_out = acc[NUM_CTX-1][WIDTH_MAC-1];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [WIDTH_A-1:0] a_lane, mul_a;
        logic signed [WIDTH_B-1:0] b_lane, mul_b;
        logic [WIDTH_A-1:0]        mag_a;
        logic [WIDTH_B-1:0]        mag_b;
        logic signed [WIDTH_P-1:0] product;

        assign a_lane = a_in[i*WIDTH_A +: WIDTH_A];
        assign b_lane = b_in[i*WIDTH_B +: WIDTH_B];
        // The most-negative value negates to itself, which read unsigned is the largest magnitude.
        assign mag_a  = a_lane[WIDTH_A-1] ? -a_lane : a_lane;
        assign mag_b  = b_lane[WIDTH_B-1] ? -b_lane : b_lane;
        assign gate[i] = (ZERO_GATING != 0) &&
                         (((mag_a >> thres) == '0) || ((mag_b >> thres) == '0));

        // Gated lanes keep feeding the multiplier the last live operands so it does not toggle.
        assign mul_a   = gate[i] ? op_a[i] : a_lane;
        assign mul_b   = gate[i] ? op_b[i] : b_lane;
        // NOTE: the product sits in its own signed assignment; folding it into the ternary with '0
        // would make the whole expression unsigned and zero-extend the operands.
        assign product = mul_a * mul_b;
        assign prod_next[i] = gate[i] ? '0 : product;
    end

    always_comb begin
        addend = s1_ctx_switch ? acc[s1_ctx_sel] : mac_in;
        sum    = addend;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + WIDTH_MAC'(prod[i]);
        end
    end

    // NOTE: acc is a small flop bank rather than a RAM, so it is cleared with the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_ctx_switch <= 1'b0;
            s1_ctx_sel    <= '0;
            zero_lanes    <= '0;
            for (int i = 0; i < LANES; i++) begin
                op_a[i] <= '0;
                op_b[i] <= '0;
                prod[i] <= '0;
            end
            acc       <= '0;
            mac_out   <= '0;
            valid_out <= 1'b0;
            cell_out  <= 1'b0;
        end else if (reg_clear) begin
            s1_valid      <= 1'b0;
            s1_ctx_switch <= 1'b0;
            s1_ctx_sel    <= '0;
            zero_lanes    <= '0;
            for (int i = 0; i < LANES; i++) begin
                op_a[i] <= '0;
                op_b[i] <= '0;
                prod[i] <= '0;
            end
            acc       <= '0;
            mac_out   <= '0;
            valid_out <= 1'b0;
            cell_out  <= 1'b0;
        end else begin
            cell_out <= cell_sc_en;
            if (scan_en) begin
                acc <= {acc_flat[NUM_CTX*WIDTH_MAC-2:0], scan_in};
            end else if (adv) begin
                s1_valid      <= valid_in;
                s1_ctx_switch <= ctx_switch;
                s1_ctx_sel    <= ctx_sel;
                zero_lanes    <= gate;
                for (int i = 0; i < LANES; i++) begin
                    prod[i] <= prod_next[i];
                    if (!gate[i]) begin
                        op_a[i] <= a_in[i*WIDTH_A +: WIDTH_A];
                        op_b[i] <= b_in[i*WIDTH_B +: WIDTH_B];
                    end
                end
                // Stage 2 reads acc from the flops, so a write here is visible to the very next op.
                if (s1_valid) begin
                    mac_out   <= sum;
                    valid_out <= 1'b1;
                    if (s1_ctx_switch) acc[s1_ctx_sel] <= sum;
                end else begin
                    valid_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_is_multictx.sv
// Directed bench for pe_is_multictx at default parameters; expected values are hand-computed.
module tb_pe_is_multictx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_in, b_in;
    logic [47:0] mac_in;
    logic        valid_in, pipeline_en, cell_en, cell_sc_en, reg_clear;
    logic        ctx_switch, scan_en, scan_in;
    logic [0:0]  ctx_sel;
    logic [3:0]  thres;
    logic [47:0] mac_out;
    logic        valid_out, cell_out, scan_out;
    logic [1:0]  zero_lanes;

    int n_cmp = 0;
    int n_bad = 0;

    pe_is_multictx dut (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .mac_in(mac_in),
        .valid_in(valid_in), .pipeline_en(pipeline_en), .cell_en(cell_en),
        .cell_sc_en(cell_sc_en), .reg_clear(reg_clear), .ctx_switch(ctx_switch),
        .ctx_sel(ctx_sel), .thres(thres), .scan_en(scan_en), .scan_in(scan_in),
        .mac_out(mac_out), .valid_out(valid_out), .cell_out(cell_out),
        .scan_out(scan_out), .zero_lanes(zero_lanes)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ops(input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] b0, input logic [15:0] b1);
        a_in = {a1, a0};
        b_in = {b1, b0};
    endtask

    task automatic issue_one();
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
    endtask

    logic [95:0] load_vec;
    logic [47:0] rd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; a_in = '0; b_in = '0; mac_in = 48'd100; valid_in = 1'b0;
        pipeline_en = 1'b1; cell_en = 1'b1; cell_sc_en = 1'b0; reg_clear = 1'b0;
        ctx_switch = 1'b0; ctx_sel = 1'b0; thres = 4'd0; scan_en = 1'b0; scan_in = 1'b0;
        step(); step();
        check("rst mac_out", mac_out, 0);
        check("rst flags", {valid_out, cell_out, scan_out, zero_lanes}, 0);
        rst_n = 1'b1;
        step();

        // Basic MAC: 3*4 + (-2)*5 + 100, two-cycle latency, single-cycle valid
        ops(16'd3, -16'sd2, 16'd4, 16'd5);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        check("lat1 valid_out", valid_out, 0);
        step();
        check("basic valid_out", valid_out, 1);
        check("basic mac_out", mac_out, 102);
        check("basic zero_lanes", zero_lanes, 2'b00);
        step();
        check("basic valid drop", valid_out, 0);
        check("basic hold", mac_out, 102);

        // Back-to-back accumulation into ctx 1
        ops(16'd1, 16'd1, 16'd2, 16'd3);
        ctx_switch = 1'b1; ctx_sel = 1'b1; valid_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k >= 2) check($sformatf("acc1 run %0d", k - 1), mac_out, 5 * (k - 1));
        end
        valid_in = 1'b0; ctx_switch = 1'b0; ctx_sel = 1'b0;
        step();
        check("acc1 final mac", mac_out, 20);
        check("acc1 value", dut.acc[1], 20);
        check("acc0 untouched", dut.acc[0], 0);

        // Threshold gating: |3| < 4 gates lane 0, lane 1 gives 56
        thres = 4'd2;
        ops(16'd3, 16'd8, 16'd7, 16'd7);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        check("thr2 zero_lanes", zero_lanes, 2'b01);
        check("thr2 op_a0 held", dut.op_a[0], 1);
        check("thr2 op_b0 held", dut.op_b[0], 2);
        step();
        check("thr2 mac_out", mac_out, 156);

        // thres=0 gates exact zeros only
        thres = 4'd0;
        ops(16'd0, 16'd5, 16'd9, 16'd2);
        issue_one();
        check("thr0 zero_lanes", zero_lanes, 2'b01);
        check("thr0 mac_out", mac_out, 110);

        // Most-negative operand counts as large; 100 < 2^15 is gated
        thres = 4'd15;
        ops(16'h8000, 16'd100, 16'h8000, 16'd100);
        issue_one();
        check("mneg zero_lanes", zero_lanes, 2'b10);
        check("mneg mac_out", mac_out, 64'd1073741924);
        thres = 4'd0;

        // 3-cycle stall mid-flight; cell_out keeps tracking cell_sc_en
        ops(16'd2, 16'd3, 16'd5, 16'd7);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0; pipeline_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cell_sc_en = ~cell_sc_en;
            step();
            check($sformatf("stall%0d valid_out", k), valid_out, 0);
            check($sformatf("stall%0d mac hold", k), mac_out, 64'd1073741924);
            check($sformatf("stall%0d cell_out", k), cell_out, cell_sc_en);
        end
        pipeline_en = 1'b1;
        step();
        check("stall valid_out", valid_out, 1);
        check("stall mac_out", mac_out, 131);
        pipeline_en = 1'b0;
        step();
        check("stall valid hold", valid_out, 1);
        pipeline_en = 1'b1;
        step();
        check("stall valid drop", valid_out, 0);

        // scan_en freezes stage-1 work, which resumes afterwards
        ops(16'd4, 16'd0, 16'd4, 16'd0);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0; scan_en = 1'b1;
        step(); step();
        check("freeze valid_out", valid_out, 0);
        check("freeze mac hold", mac_out, 131);
        scan_en = 1'b0;
        step();
        check("resume valid_out", valid_out, 1);
        check("resume mac_out", mac_out, 116);

        // Two's-complement wrap
        mac_in = 48'h7FFF_FFFF_FFFF;
        ops(16'd1, 16'd0, 16'd1, 16'd0);
        issue_one();
        check("wrap mac_out", mac_out, 48'h8000_0000_0000);
        mac_in = 48'd100;

        // Scan-load both contexts, then read acc[1] out MSB first
        load_vec = {48'h8000_0000_0001, 48'hA5A5_0000_1234};
        scan_en = 1'b1;
        for (int i = 0; i < 96; i++) begin
            scan_in = load_vec[95 - i];
            step();
        end
        check("scan load acc1", dut.acc[1], 48'h8000_0000_0001);
        check("scan load acc0", dut.acc[0], 48'hA5A5_0000_1234);
        scan_in = 1'b0;
        for (int i = 0; i < 48; i++) begin
            rd[47 - i] = scan_out;
            step();
        end
        check("scan readout", rd, 48'h8000_0000_0001);
        check("scan shift acc1", dut.acc[1], 48'hA5A5_0000_1234);
        scan_en = 1'b0;

        // reg_clear together with scan_en flushes everything, including in-flight work
        ops(16'd0, 16'd3, 16'd5, 16'd7);
        cell_sc_en = 1'b1; valid_in = 1'b1;
        step(); step();
        check("pre-clr outputs", {valid_out, cell_out, scan_out, zero_lanes, mac_out},
              {1'b1, 1'b1, 1'b1, 2'b01, 48'd121});
        valid_in = 1'b0; reg_clear = 1'b1; scan_en = 1'b1; scan_in = 1'b1;
        step();
        check("clr mac_out", mac_out, 0);
        check("clr flags", {valid_out, cell_out, scan_out, zero_lanes}, 0);
        check("clr acc", dut.acc, 0);
        reg_clear = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
        step();
        check("clr flushed", valid_out, 0);

        // Asynchronous reset in the middle of a stall
        ops(16'd2, 16'd3, 16'd5, 16'd7);
        issue_one();
        valid_in = 1'b1;
        step();
        valid_in = 1'b0; pipeline_en = 1'b0;
        step();
        check("pre-rst outputs", {cell_out, mac_out}, {1'b1, 48'd131});
        #2 rst_n = 1'b0;
        #1;
        check("arst mac_out", mac_out, 0);
        check("arst flags", {valid_out, cell_out, scan_out, zero_lanes}, 0);
        @(negedge clk);
        rst_n = 1'b1; pipeline_en = 1'b1;
        step();
        check("arst flushed", valid_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pe_is_multictx.md
PE_IS_MULTICTX -- requirements
Module: pe_is_multictx

Interface
REQ-001 SHALL have parameter WIDTH_A, default 16, signed activation width per lane.
REQ-002 SHALL have parameter WIDTH_B, default 16, signed weight width per lane.
REQ-003 SHALL have parameter WIDTH_MAC, default 48, signed accumulator width; legal range is WIDTH_MAC >= WIDTH_A+WIDTH_B+LANES.
REQ-004 SHALL have parameter LANES, default 2, number of parallel multiply lanes, legal range 1..8.
REQ-005 SHALL have parameter NUM_CTX, default 2, number of local accumulator contexts, power of two, legal range 2..8; CW = log2(NUM_CTX).
REQ-006 SHALL have parameter WIDTH_T, default 4, zero-threshold width.
REQ-007 SHALL have parameter ZERO_GATING, default 1; 0 disables zero gating entirely.
REQ-008 Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
a_in  in  LANES*WIDTH_A  activations, lane i at bits [i*WIDTH_A +: WIDTH_A]
b_in  in  LANES*WIDTH_B  weights, same packing as a_in
mac_in  in  WIDTH_MAC  partial sum from upstream PE
valid_in  in  1  operands valid this cycle
pipeline_en  in  1  global advance; 0 stalls the whole pipe
cell_en  in  1  PE enable; compute advances only when pipeline_en & cell_en
cell_sc_en  in  1  enable forwarded to the next PE
reg_clear  in  1  synchronous clear
ctx_switch  in  1  0 = addend is mac_in, 1 = addend is acc[ctx_sel]
ctx_sel  in  CW  accumulator context index
thres  in  WIDTH_T  zero threshold exponent
scan_en  in  1  serial readout of the accumulator bank
scan_in  in  1  scan chain input
mac_out  out  WIDTH_MAC  registered MAC result
valid_out  out  1  mac_out holds a new result
cell_out  out  1  registered cell_sc_en
scan_out  out  1  scan chain output
zero_lanes  out  LANES  registered per-lane gate flags of the last issued operand set

Function
REQ-009 Define adv = pipeline_en & cell_en & ~scan_en; no compute register changes when adv=0.
REQ-010 Zero detect: lane i SHALL be gated when ZERO_GATING=1 and either |a_i| < 2^thres or |b_i| < 2^thres, using the unsigned magnitude with the most-negative value treated as non-zero; thres=0 gates exact zeros only.
REQ-011 Stage 1 (on adv): SHALL register p_i = a_i*b_i as a signed full-width product, forced to 0 when gated; the multiplier inputs of gated lanes SHALL be held at their previous values; it SHALL also register valid_in, ctx_switch, ctx_sel and the gate flags (to zero_lanes).
REQ-012 Stage 2 (on adv): SHALL compute sum = sign-extended sum of all p_i + addend, truncated to WIDTH_MAC with two's-complement wrap and no saturation; the addend SHALL be mac_in sampled in stage 2 when the stage-1 ctx_switch=0, else acc[stage-1 ctx_sel].
REQ-013 When stage-1 valid=1, stage 2 SHALL load mac_out<=sum and valid_out<=1, and if ctx_switch=1 also acc[ctx_sel]<=sum; when valid=0 it SHALL set valid_out<=0, hold mac_out, and leave acc unchanged.
REQ-014 Latency: exactly 2 adv cycles from valid_in to valid_out; stalled cycles are not counted, and valid_out and mac_out hold during a stall.
REQ-015 Back-to-back accumulation into the same ctx SHALL see the previous result (read-after-write bypass from stage 2 to the addend); no bubble is required.
REQ-016 cell_out SHALL register cell_sc_en every cycle, independent of adv and scan_en.
REQ-017 Scan: while scan_en=1, the bank acc[NUM_CTX-1]..acc[0] SHALL form one NUM_CTX*WIDTH_MAC chain that shifts one bit per clk; scan_out = MSB of acc[NUM_CTX-1]; scan_in enters at the LSB of acc[0]; each acc MSB feeds the LSB of the next higher acc.
REQ-018 scan_en SHALL override compute; asserting it with work in stage 1 freezes that work, which resumes when scan_en falls.
REQ-019 Simultaneous events: priority order is reg_clear > scan_en > adv.

Reset
REQ-020 rst_n=0 SHALL asynchronously clear all stage registers, every acc, mac_out, valid_out, cell_out, zero_lanes and scan_out to 0.
REQ-021 reg_clear=1 SHALL clear the same state on the next edge, flushing any in-flight operation, regardless of pipeline_en, cell_en or scan_en.

Verification
REQ-022 LANES=2, a=(3,-2), b=(4,5), mac_in=100, ctx_switch=0, thres=0, one valid -> two cycles later mac_out=102, valid_out=1 for 1 cycle.
REQ-023 ctx_switch=1, ctx_sel=1, four consecutive valids with a=(1,1), b=(2,3) -> acc[1]=5,10,15,20; acc[0] stays 0 (bypass check).
REQ-024 thres=2, a=(3,8), b=(7,7) -> zero_lanes=01, result equals 56 plus the addend; lane-0 multiplier inputs unchanged.
REQ-025 pipeline_en dropped for 3 cycles mid-flight -> valid_out delayed by exactly 3 cycles, value unchanged; cell_out still tracks cell_sc_en with 1 cycle delay.
REQ-026 acc[1]=0x8000_0000_0001 (WIDTH_MAC=48), scan_en for 48 cycles -> scan_out emits 1,0...0,1 MSB first; sum overflow of 0x7FFF_FFFF_FFFF+1 -> 0x8000_0000_0000.
REQ-027 rst_n pulsed low asynchronously mid-stall, and separately reg_clear together with scan_en -> all outputs 0 immediately and on the next edge respectively.
